// File: rtl/apb_reg_slave.sv
// APB completer exposing a bank of byte-strobed control registers with
// optional read-only status slots, programmable wait states and PSLVERR.
module apb_reg_slave #(
  parameter int                  ADDR_WIDTH  = 32,
  parameter int                  DATA_WIDTH  = 32,
  parameter int                  NUM_REGS    = 16,
  parameter int                  WAIT_STATES = 0,
  parameter logic [NUM_REGS-1:0] RO_MASK     = '0
) (
  input  logic                           PCLK,
  input  logic                           PRESETn,
  input  logic                           PSEL,
  input  logic                           PENABLE,
  input  logic [ADDR_WIDTH-1:0]          PADDR,
  input  logic                           PWRITE,
  input  logic [DATA_WIDTH-1:0]          PWDATA,
  input  logic [DATA_WIDTH/8-1:0]        PSTRB,
  input  logic [2:0]                     PPROT,
  output logic                           PREADY,
  output logic [DATA_WIDTH-1:0]          PRDATA,
  output logic                           PSLVERR,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] status_i,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

  localparam int STRB_W    = DATA_WIDTH / 8;
  localparam int BYTE_BITS = $clog2(STRB_W);
  localparam int IDX_BITS  = $clog2(NUM_REGS);
  localparam int DEC_BITS  = BYTE_BITS + IDX_BITS;
  localparam int WCNT_W    = 4;

  localparam logic [WCNT_W-1:0]     WAIT_LAST = WCNT_W'(WAIT_STATES);
  localparam logic [ADDR_WIDTH-1:0] LANE_MASK = ADDR_WIDTH'(STRB_W - 1);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACCESS = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [WCNT_W-1:0]     wcnt_q, wcnt_d;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [DATA_WIDTH-1:0] reg_view [NUM_REGS];

  logic                  aligned;
  logic                  in_range;
  logic [IDX_BITS-1:0]   idx;
  logic                  err;
  logic                  pready;
  logic                  commit;
  logic [DATA_WIDTH-1:0] rdata;

  // Protection attributes are accepted but carry no meaning for this bank;
  // status_i slices for writable registers are likewise never observed.
  logic unused_inputs;
  assign unused_inputs = ^{PPROT, status_i};

  // ---------------------------------------------------------------------
  // Address decode and error classification
  // ---------------------------------------------------------------------
  assign aligned  = (PADDR & LANE_MASK) == '0;
  assign in_range = (PADDR >> DEC_BITS) == '0;
  assign idx      = PADDR[BYTE_BITS +: IDX_BITS];
  assign err      = !aligned || !in_range || (PWRITE && RO_MASK[idx]);

  assign pready = (state_q == ACCESS) && (wcnt_q == WAIT_LAST);
  assign commit = pready && PSEL && PENABLE;

  // ---------------------------------------------------------------------
  // Register view: read-only slots mirror status_i, the rest are storage
  // ---------------------------------------------------------------------
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_view
    if (RO_MASK[i]) begin : g_ro
      assign reg_view[i] = status_i[i*DATA_WIDTH +: DATA_WIDTH];
    end else begin : g_rw
      assign reg_view[i] = regs_q[i];
    end
    assign regs_o[i*DATA_WIDTH +: DATA_WIDTH] = reg_view[i];
  end

  assign rdata = reg_view[idx];

  // Read data and error are only driven in the completing cycle so the
  // bus sees zeros whenever PREADY is low.
  assign PREADY  = pready;
  assign PRDATA  = (pready && !PWRITE && !err) ? rdata : '0;
  assign PSLVERR = pready && err;

  // ---------------------------------------------------------------------
  // Transfer FSM
  // ---------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    state_d = state_q;
    wcnt_d  = wcnt_q;
    unique case (state_q)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          state_d = ACCESS;
          wcnt_d  = '0;
        end
      end
      ACCESS: begin
        if (!PSEL) begin
          state_d = IDLE;
        end else if (commit) begin
          state_d = IDLE;
        end else if (wcnt_q != WAIT_LAST) begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Byte-strobed register update; error transfers leave state untouched
  // ---------------------------------------------------------------------
  always_comb begin
    regs_d = regs_q;
    if (commit && PWRITE && !err) begin
      for (int k = 0; k < STRB_W; k++) begin
        if (PSTRB[k]) begin
          regs_d[idx][8*k +: 8] = PWDATA[8*k +: 8];
        end
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values,
      // independent of statement order.
      state_q <= IDLE;
      wcnt_q  <= '0;
      // NOTE: the register bank is built from flops rather than a RAM, so it can
      // and must be reset; a RAM macro would have no reset port.
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

endmodule

// File: tb/tb_apb_reg_slave.sv
// Directed bench for apb_reg_slave: stimulus pushes expected completions into
// a scoreboard queue that a free-running monitor drains on each PREADY beat.
module tb_apb_reg_slave;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NR = 16;
  localparam int WS = 2;
  localparam logic [NR-1:0] RO = 16'h8000;

  logic           PCLK;
  logic           PRESETn;
  logic           PSEL;
  logic           PENABLE;
  logic [AW-1:0]  PADDR;
  logic           PWRITE;
  logic [DW-1:0]  PWDATA;
  logic [DW/8-1:0] PSTRB;
  logic [2:0]     PPROT;
  logic           PREADY;
  logic [DW-1:0]  PRDATA;
  logic           PSLVERR;
  logic [NR*DW-1:0] status_i;
  logic [NR*DW-1:0] regs_o;

  apb_reg_slave #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NUM_REGS   (NR),
    .WAIT_STATES(WS),
    .RO_MASK    (RO)
  ) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PADDR   (PADDR),
    .PWRITE  (PWRITE),
    .PWDATA  (PWDATA),
    .PSTRB   (PSTRB),
    .PPROT   (PPROT),
    .PREADY  (PREADY),
    .PRDATA  (PRDATA),
    .PSLVERR (PSLVERR),
    .status_i(status_i),
    .regs_o  (regs_o)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  typedef struct packed {
    logic        chk_data;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        sb_q [$];
  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [31:0] model [NR];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < NR; i++) begin
      check($sformatf("%s_reg%0d", tag, i), regs_o[i*DW +: DW], model[i]);
    end
  endtask

  // Monitor: every completing beat must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge PCLK);
      if (PRESETn && PSEL && PENABLE && PREADY) begin
        n_cmp++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_completion: got PREADY=1 at addr 0x%08h, expected no transfer", PADDR);
        end else begin
          e = sb_q.pop_front();
          check($sformatf("pslverr@%08h", PADDR), 32'(PSLVERR), 32'(e.err));
          if (e.chk_data) check($sformatf("prdata@%08h", PADDR), PRDATA, e.data);
        end
      end
    end
  end

  // One full transfer starting #1 after an edge; returns total cycles and the
  // number of ACCESS cycles that had PREADY low.
  task automatic apb_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                          input logic [3:0] strb, input logic [31:0] exp_rd,
                          input logic exp_err, output int cycles, output int low_cnt);
    logic rdy;
    logic done;
    PSEL    = 1'b1;
    PENABLE = 1'b0;
    PADDR   = addr;
    PWRITE  = wr;
    PWDATA  = wd;
    PSTRB   = strb;
    sb_q.push_back(exp_t'{chk_data: !wr, data: exp_rd, err: exp_err});
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    cycles  = 1;
    low_cnt = 0;
    done    = 1'b0;
    for (int n = 0; n < 20 && !done; n++) begin
      rdy = PREADY;
      if (!rdy) low_cnt++;
      @(posedge PCLK); #1;
      cycles++;
      done = rdy;
    end
    if (!done) begin
      n_cmp++;
      n_fail++;
      $display("FAIL timeout@%08h: got no PREADY in 20 cycles, expected completion", addr);
    end
    PSEL    = 1'b0;
    PENABLE = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish before 200us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c1, c2, lo;
    PRESETn  = 1'b0;
    PSEL     = 1'b0;
    PENABLE  = 1'b0;
    PADDR    = '0;
    PWRITE   = 1'b0;
    PWDATA   = '0;
    PSTRB    = '0;
    PPROT    = '0;
    status_i = '0;
    for (int i = 0; i < NR; i++) model[i] = '0;

    // Reset values
    #3;
    check("rst_pready",  32'(PREADY),  32'd0);
    check("rst_prdata",  PRDATA,       32'd0);
    check("rst_pslverr", 32'(PSLVERR), 32'd0);
    check_regs("rst");
    @(posedge PCLK); #1;
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    @(posedge PCLK); #1;

    // Reset during ACCESS of a write to reg1; bus stays asserted afterwards
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = 32'h4; PWRITE = 1'b1;
    PWDATA = 32'hDEAD_BEEF; PSTRB = 4'hF;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PRESETn = 1'b0;
    #1;
    check("midrst_pready", 32'(PREADY), 32'd0);
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge PCLK); #1;
      check($sformatf("postrst_pready_%0d", i), 32'(PREADY), 32'd0);
    end
    check("midrst_reg1", regs_o[1*DW +: DW], 32'd0);
    PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK); #1;

    // Write then read reg2 with wait-state timing
    apb_xfer(32'h08, 1'b1, 32'hA5A5_1234, 4'hF, 32'h0, 1'b0, c1, lo);
    model[2] = 32'hA5A5_1234;
    check("wr_cycles", 32'(c1), 32'd4);
    check("wr_low",    32'(lo), 32'd2);
    check("wr_reg2",   regs_o[2*DW +: DW], model[2]);
    apb_xfer(32'h08, 1'b0, 32'h0, 4'h0, 32'hA5A5_1234, 1'b0, c1, lo);
    check("rd_cycles", 32'(c1), 32'd4);
    check("rd_low",    32'(lo), 32'd2);

    // Byte strobes, then a no-effect zero-strobe write
    apb_xfer(32'h08, 1'b1, 32'hFFFF_FFFF, 4'b0101, 32'h0, 1'b0, c1, lo);
    model[2] = 32'hA5FF_12FF;
    check("strb_reg2", regs_o[2*DW +: DW], model[2]);
    apb_xfer(32'h08, 1'b1, 32'h0000_0000, 4'b0000, 32'h0, 1'b0, c1, lo);
    apb_xfer(32'h08, 1'b0, 32'h0, 4'h0, 32'hA5FF_12FF, 1'b0, c1, lo);

    // Errors: read-only write, read-only read, out of range, misaligned
    status_i[15*DW +: DW] = 32'h0000_CAFE;
    model[15] = 32'h0000_CAFE;
    apb_xfer(32'h3C, 1'b1, 32'h0000_0001, 4'hF, 32'h0, 1'b1, c1, lo);
    check_regs("rowr");
    apb_xfer(32'h3C, 1'b0, 32'h0, 4'h0, 32'h0000_CAFE, 1'b0, c1, lo);
    apb_xfer(32'h40, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, c1, lo);
    apb_xfer(32'h06, 1'b1, 32'h1234_5678, 4'hF, 32'h0, 1'b1, c1, lo);
    apb_xfer(32'h06, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, c1, lo);
    check_regs("misal");

    // Back-to-back writes with no idle cycle between them
    apb_xfer(32'h0C, 1'b1, 32'h1111_1111, 4'hF, 32'h0, 1'b0, c1, lo);
    apb_xfer(32'h10, 1'b1, 32'h2222_2222, 4'hF, 32'h0, 1'b0, c2, lo);
    model[3] = 32'h1111_1111;
    model[4] = 32'h2222_2222;
    check("b2b_cycles", 32'(c1 + c2), 32'd8);
    check_regs("b2b");

    // Abort: PSEL dropped during the second ACCESS cycle
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = 32'h14; PWRITE = 1'b1;
    PWDATA = 32'h0000_0055; PSTRB = 4'hF;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    check("abort_pready", 32'(PREADY), 32'd0);
    @(posedge PCLK); #1;
    check("abort_reg5", regs_o[5*DW +: DW], 32'd0);
    apb_xfer(32'h14, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, c1, lo);
    check("post_abort_cycles", 32'(c1), 32'd4);
    apb_xfer(32'h10, 1'b0, 32'h0, 4'h0, 32'h2222_2222, 1'b0, c1, lo);

    repeat (3) @(posedge PCLK);
    #1;
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
